pn_audio_feeder: RTL and testbench
==================================

// Module: pn_audio_feeder
// PURPOSE
//  Upstream stage of the I2S transmitter. Buffers 16-bit mono demodulated samples that arrive
//  in bursts from the PN receiver DSP chain and releases them at exactly 8 kHz
//  (ax_clk/2048, ax_clk = 16.384 MHz). Each sample is presented as a 32-bit stereo word,
//  {right[31:16], left[15:0]}, on the transmitter's tx_ax_s_* inputs.
//  Also counts underruns and overruns.
// PARAMETERS
//  DEPTH      16    FIFO depth in samples; power of 2, >= 4
//  DIV        2048  ax_clk cycles per output frame (8 kHz at 16.384 MHz)
//  MUTE_UFLOW 1     1: output 0 on underrun; 0: repeat the last sample
// PORTS
//  ax_clk        in   1   single clock, 16.384 MHz; all logic is posedge
//  ax_rstn       in   1   asynchronous, active-low reset
//  enable        in   1   1 = pacing runs; 0 = pacing frozen, FIFO still accepts input
//  s_data        in   16  signed mono sample from the demodulator
//  s_valid       in   1   s_data is valid
//  s_ready       out  1   FIFO can accept a sample
//  m_data        out  32  {sample, sample}; connects to tx_ax_s_data
//  m_valid       out  1   new frame word present; connects to tx_ax_s_valid
//  m_ready       in   1   consumer took the word; connects to tx_ax_s_ready
//  fill          out  $clog2(DEPTH)+1  current FIFO occupancy
//  uflow_cnt     out  16  saturating count of ticks that found the FIFO empty
//  oflow_cnt     out  16  saturating count of frames overwritten while m_valid=1
// BEHAVIOUR
//  Reset values: s_ready=0 while ax_rstn=0, then 1; m_data=0; m_valid=0; fill=0; counters=0;
//    pace counter=0.
//  Input path:
//  - Push when s_valid && s_ready. s_ready = (fill != DEPTH), registered from state.
//  - A push and a pop in the same cycle leave fill unchanged. A push is accepted when
//    fill == DEPTH-1 even if a pop occurs in that cycle.
//  Pacing:
//  - pace counter counts 0..DIV-1 and wraps. tick = enable && (pace == DIV-1).
//  - enable=0 holds pace at 0 and clears m_valid; m_data keeps its value.
//  - The first tick occurs DIV cycles after enable rises.
//  On tick (m_data and m_valid update on the cycle after tick):
//  - FIFO not empty: pop; m_data <= {q,q}; m_valid <= 1.
//  - FIFO empty: m_data <= MUTE_UFLOW ? 0 : m_data; m_valid <= 1; uflow_cnt += 1,
//    saturating at 16'hFFFF.
//  - m_valid is already 1 and m_ready is not 1 in the tick cycle: the word is overwritten
//    and oflow_cnt += 1, saturating. The overflow check and the underrun check are
//    independent; both may count on the same tick.
//  - There is no bypass: a sample pushed into an empty FIFO in the tick cycle is not
//    popped until the next tick. Minimum latency from push to m_data is 2 cycles; maximum
//    is DIV*(fill+1)+1.
//  Other m_valid rules:
//  - m_valid clears on the cycle after m_valid && m_ready, except when a tick in that
//    cycle sets it again.
//  - m_data is stable between ticks regardless of m_ready. The I2S stage samples it at
//    LRCLK edges, so stability is mandatory.
//  Reset asserted mid-operation: the FIFO is flushed (pointers cleared), all outputs
//    return to their reset values immediately, and the counters clear.
//  Arithmetic: pointers are log2(DEPTH)+1 bits with an MSB wrap flag.
//    full  = ptrs differ only in MSB.
//    empty = ptrs equal.
//  Samples pass through unmodified; there is no gain or rounding.
// STRUCTURE
//  Package pn_audio_pkg:
//    SAMPLE_W=16, FRAME_W=32, FS_DIV=2048.
//    function sat_inc16.
//  Sub-module pn_sync_fifo (WIDTH, DEPTH):
//    - single clock, async active-low reset, first-word-fall-through.
//    - ports: wr_en, wr_data, rd_en, rd_data, full, empty, fill.
//  The top level holds the pace counter, the output register, the handshake logic and the
//    counters.
// TESTING
//  1. Reset, enable=1, push 3 samples 0x1234, 0x8001, 0x7FFF at cycle 10:
//     -> m_data = 0x12341234 at cycle 2049, 0x80018001 at 4097, 0x7FFF7FFF at 6145.
//  2. Push 20 samples back-to-back with DEPTH=16, enable=0:
//     -> s_ready drops after the 16th accept; fill=16; samples 17-20 stall;
//        uflow_cnt=oflow_cnt=0.
//  3. FIFO empty at a tick, MUTE_UFLOW=1 -> m_data=0, uflow_cnt=1.
//     Same with MUTE_UFLOW=0 -> m_data keeps the previous value.
//  4. Hold m_ready=0 across 3 ticks -> oflow_cnt=2, m_data shows the newest sample.
//     Then pulse m_ready -> m_valid=0 on the next cycle.
//  5. Push a sample into an empty FIFO in the tick cycle -> uflow_cnt+1 for that tick;
//     the sample appears at the next tick.
//  6. Assert ax_rstn=0 for 1 cycle with fill=5 mid-frame -> outputs and fill=0 at once.
//     The next m_data update occurs DIV cycles after reset is released.

Source files
------------

// File: rtl/pn_audio_pkg.sv
// Shared widths, frame divider and helpers for the PN audio feeder.
package pn_audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned FS_DIV   = 2048;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [FRAME_W-1:0]  frame_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pn_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-flag pointers.
module pn_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign fill    = r_wr_ptr - r_rd_ptr;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pn_audio_feeder.sv
// Buffers bursty mono samples and releases one stereo frame word every DIV cycles.
module pn_audio_feeder
  import pn_audio_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DIV        = FS_DIV,
  parameter bit          MUTE_UFLOW = 1'b1
) (
  input  logic                      ax_clk,
  input  logic                      ax_rstn,
  input  logic                      enable,
  input  logic [SAMPLE_W-1:0]       s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [FRAME_W-1:0]        m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [15:0]               uflow_cnt,
  output logic [15:0]               oflow_cnt
);

  localparam int unsigned FW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]       r_pace;
  logic                r_s_ready;
  logic [FRAME_W-1:0]  r_m_data;
  logic                r_m_valid;
  logic [15:0]         r_uflow;
  logic [15:0]         r_oflow;

  logic                w_tick;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FW-1:0]       w_fill;
  logic [FW-1:0]       w_fill_next;
  sample_t             w_q;

  assign w_tick      = enable && (r_pace == PW'(DIV - 1));
  assign w_push      = s_valid && r_s_ready && !w_full;
  assign w_pop       = w_tick && !w_empty;
  assign w_fill_next = w_fill + FW'(w_push) - FW'(w_pop);

  assign s_ready   = r_s_ready;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign fill      = w_fill;
  assign uflow_cnt = r_uflow;
  assign oflow_cnt = r_oflow;

  pn_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ax_clk),
    .rst_n   (ax_rstn),
    .wr_en   (w_push),
    .wr_data (s_data),
    .rd_en   (w_pop),
    .rd_data (w_q),
    .full    (w_full),
    .empty   (w_empty),
    .fill    (w_fill)
  );

  // Frame pacing counter; frozen at zero while disabled.
  always_ff @(posedge ax_clk or negedge ax_rstn) begin
    if (!ax_rstn)                       r_pace <= '0;
    else if (!enable)                   r_pace <= '0;
    else if (r_pace == PW'(DIV - 1))    r_pace <= '0;
    else                                r_pace <= r_pace + PW'(1);
  end

  // Registered ready, computed from next-cycle occupancy so it is held low in reset.
  always_ff @(posedge ax_clk or negedge ax_rstn) begin
    if (!ax_rstn) r_s_ready <= 1'b0;
    else          r_s_ready <= (w_fill_next != FW'(DEPTH));
  end

  // Output word and valid flag; data only changes on a tick.
  always_ff @(posedge ax_clk or negedge ax_rstn) begin
    if (!ax_rstn) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (!enable) begin
      r_m_valid <= 1'b0;
    end else if (w_tick) begin
      r_m_valid <= 1'b1;
      if (!w_empty)        r_m_data <= {w_q, w_q};
      else if (MUTE_UFLOW) r_m_data <= '0;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Underrun and overwrite counters, independent of each other.
  always_ff @(posedge ax_clk or negedge ax_rstn) begin
    if (!ax_rstn) begin
      r_uflow <= '0;
      r_oflow <= '0;
    end else begin
      if (w_tick && w_empty)                r_uflow <= sat_inc16(r_uflow);
      if (w_tick && r_m_valid && !m_ready)  r_oflow <= sat_inc16(r_oflow);
    end
  end

endmodule

// File: tb/tb_pn_audio_feeder.sv
module tb_pn_audio_feeder;

  logic        clk = 1'b0;
  logic        rstn;
  // main instance: DEPTH=16, DIV=2048, muted underrun
  logic        en, sv, sr, mv, mr;
  logic [15:0] sd, uf, of;
  logic [31:0] md;
  logic [4:0]  fl;
  // second instance: DEPTH=4, DIV=64, repeat-last on underrun
  logic        en1, sv1, sr1, mv1, mr1;
  logic [15:0] sd1, uf1, of1;
  logic [31:0] md1;
  logic [2:0]  fl1;

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = 0;

  always #5 clk = ~clk;

  pn_audio_feeder #(.DEPTH(16), .DIV(2048), .MUTE_UFLOW(1'b1)) u0 (
    .ax_clk(clk), .ax_rstn(rstn), .enable(en), .s_data(sd), .s_valid(sv),
    .s_ready(sr), .m_data(md), .m_valid(mv), .m_ready(mr), .fill(fl),
    .uflow_cnt(uf), .oflow_cnt(of)
  );

  pn_audio_feeder #(.DEPTH(4), .DIV(64), .MUTE_UFLOW(1'b0)) u1 (
    .ax_clk(clk), .ax_rstn(rstn), .enable(en1), .s_data(sd1), .s_valid(sv1),
    .s_ready(sr1), .m_data(md1), .m_valid(mv1), .m_ready(mr1), .fill(fl1),
    .uflow_cnt(uf1), .oflow_cnt(of1)
  );

  typedef struct {
    logic [15:0] data;
    logic        exp_ready;
    logic [4:0]  exp_fill;
  } vec_t;
  vec_t tv [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (ecnt < target) begin
      cyc();
      ecnt++;
    end
  endtask

  task automatic push1(input logic [15:0] d);
    sv = 1'b1; sd = d;
    cyc(); ecnt++;
    sv = 1'b0;
  endtask

  initial begin
    // backpressure table: 16 accepted, then stalls
    for (int i = 0; i < 20; i++) begin
      tv[i].data      = 16'h0100 + 16'(i);
      tv[i].exp_ready = (i < 16);
      tv[i].exp_fill  = (i < 16) ? 5'(i + 1) : 5'd16;
    end

    rstn = 1'b0; en = 1'b0; sv = 1'b0; sd = '0; mr = 1'b0;
    en1 = 1'b0; sv1 = 1'b0; sd1 = '0; mr1 = 1'b1;
    repeat (3) cyc();
    chk("rst_s_ready", 32'(sr), 32'd0);
    chk("rst_m_data",  md, 32'd0);
    chk("rst_m_valid", 32'(mv), 32'd0);
    chk("rst_fill",    32'(fl), 32'd0);
    chk("rst_uflow",   32'(uf), 32'd0);
    chk("rst_oflow",   32'(of), 32'd0);
    rstn = 1'b1;
    cyc();
    chk("ready_after_rst", 32'(sr), 32'd1);

    // basic pacing: three samples, one per frame
    en = 1'b1; ecnt = 0;
    run_to(9);
    sv = 1'b1; sd = 16'h1234; run_to(10);
    sd = 16'h8001; run_to(11);
    sd = 16'h7FFF; run_to(12);
    sv = 1'b0;
    chk("fill3", 32'(fl), 32'd3);
    run_to(2047);
    chk("pre_tick_data",  md, 32'd0);
    chk("pre_tick_valid", 32'(mv), 32'd0);
    run_to(2048);
    chk("tick1_data",  md, 32'h12341234);
    chk("tick1_valid", 32'(mv), 32'd1);
    chk("tick1_fill",  32'(fl), 32'd2);
    mr = 1'b1;
    run_to(2049);
    chk("valid_clr", 32'(mv), 32'd0);
    chk("data_stable", md, 32'h12341234);
    run_to(4096);
    chk("tick2_data", md, 32'h80018001);
    run_to(6144);
    chk("tick3_data", md, 32'h7FFF7FFF);
    chk("tick3_fill", 32'(fl), 32'd0);
    chk("tick3_uflow", 32'(uf), 32'd0);

    // underrun with mute
    run_to(8191);
    chk("pre_uf_data", md, 32'h7FFF7FFF);
    run_to(8192);
    chk("uf_mute_data",  md, 32'd0);
    chk("uf_cnt1",       32'(uf), 32'd1);
    chk("uf_valid",      32'(mv), 32'd1);

    // push into empty FIFO during the tick cycle: no bypass
    run_to(10239);
    push1(16'h0ABC);
    chk("nobyp_uflow", 32'(uf), 32'd2);
    chk("nobyp_data",  md, 32'd0);
    chk("nobyp_fill",  32'(fl), 32'd1);
    run_to(12288);
    chk("nobyp_next", md, 32'h0ABC0ABC);
    chk("nobyp_uf_hold", 32'(uf), 32'd2);

    // overwrite: m_ready low across 3 ticks
    run_to(12290);
    mr = 1'b0;
    push1(16'h1111); push1(16'h2222); push1(16'h3333);
    run_to(14336);
    chk("ovf_t1_data", md, 32'h11111111);
    chk("ovf_t1_cnt",  32'(of), 32'd0);
    run_to(16384);
    chk("ovf_t2_cnt",  32'(of), 32'd1);
    run_to(18432);
    chk("ovf_t3_cnt",  32'(of), 32'd2);
    chk("ovf_t3_data", md, 32'h33333333);
    chk("ovf_uf_hold", 32'(uf), 32'd2);
    mr = 1'b1; run_to(18433); mr = 1'b0;
    chk("pulse_clr", 32'(mv), 32'd0);
    chk("pulse_data", md, 32'h33333333);

    // reset mid-frame with fill=5
    for (int i = 0; i < 5; i++) push1(16'h00A0 + 16'(i));
    chk("pre_rst_fill", 32'(fl), 32'd5);
    run_to(19000);
    rstn = 1'b0;
    #2;
    chk("mrst_fill",   32'(fl), 32'd0);
    chk("mrst_data",   md, 32'd0);
    chk("mrst_valid",  32'(mv), 32'd0);
    chk("mrst_ready",  32'(sr), 32'd0);
    chk("mrst_uflow",  32'(uf), 32'd0);
    chk("mrst_oflow",  32'(of), 32'd0);
    cyc();
    rstn = 1'b1; ecnt = 0; mr = 1'b1;
    run_to(1);
    push1(16'h4242);
    run_to(2047);
    chk("post_rst_pre", md, 32'd0);
    run_to(2048);
    chk("post_rst_tick", md, 32'h42424242);
    chk("post_rst_uf",   32'(uf), 32'd0);

    // backpressure with pacing frozen
    en = 1'b0;
    cyc();
    chk("dis_valid", 32'(mv), 32'd0);
    for (int i = 0; i < 20; i++) begin
      sv = 1'b1; sd = tv[i].data;
      chk($sformatf("bp_ready%0d", i), 32'(sr), 32'(tv[i].exp_ready));
      cyc();
      chk($sformatf("bp_fill%0d", i), 32'(fl), 32'(tv[i].exp_fill));
    end
    sv = 1'b0;
    cyc();
    chk("bp_fill_end", 32'(fl), 32'd16);
    chk("bp_ready_end", 32'(sr), 32'd0);
    chk("bp_uflow", 32'(uf), 32'd0);
    chk("bp_oflow", 32'(of), 32'd0);
    chk("bp_data_kept", md, 32'h42424242);

    // repeat-last on underrun (second instance)
    en1 = 1'b1; ecnt = 0;
    sv1 = 1'b1; sd1 = 16'h5555;
    run_to(1);
    sv1 = 1'b0;
    run_to(63);
    chk("u1_pre", md1, 32'd0);
    chk("u1_fill", 32'(fl1), 32'd1);
    run_to(64);
    chk("u1_tick", md1, 32'h55555555);
    run_to(65);
    chk("u1_clr", 32'(mv1), 32'd0);
    run_to(128);
    chk("u1_hold_data", md1, 32'h55555555);
    chk("u1_uflow", 32'(uf1), 32'd1);
    chk("u1_valid", 32'(mv1), 32'd1);
    chk("u1_oflow", 32'(of1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
